// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and rx state encoding; PARITY state exists only with UART_RX_PARITY_EN
package uart_pkg;
  localparam int OS_RATE   = 16;
  localparam int OS_MID    = 7;
  localparam int OS_LAST   = 15;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    ST_PARITY = 3'd5
`endif
  } rx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick, high for one CLK every OS_DIV cycles
module uart_baud_tick #(
  parameter int OS_DIV = 2604,
  parameter int DIV_W  = 12
) (
  input  logic CLK,
  input  logic rst_n,
  output logic tick
);
  logic [DIV_W-1:0] r_cnt;
  assign tick = (r_cnt == DIV_W'(OS_DIV - 1));
  // count 0..OS_DIV-1 and wrap
  always_ff @(posedge CLK)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x oversampling UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined
module uart_rx_os16 import uart_pkg::*; #(
  parameter int OS_DIV = 2604,
  parameter int DIV_W  = 12
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       dout_rdy,
  output logic [7:0] dout_byte,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int OS_W  = $clog2(OS_RATE);
  localparam int IDX_W = $clog2(DATA_BITS);
  logic w_tick, w_par_bad, w_mid;
  logic r_rx_meta, r_rx_sync, r_armed;
  logic [1:0] r_flush;
  rx_state_t r_state;
  logic [OS_W-1:0] r_os;
  logic [IDX_W-1:0] r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic r_dout_rdy, r_frame_err, r_par_err;
  logic [7:0] r_dout_byte;

  uart_baud_tick #(.OS_DIV(OS_DIV), .DIV_W(DIV_W)) u_tick (.CLK(CLK), .rst_n(rst_n), .tick(w_tick));

  assign w_mid      = w_tick && (r_os == OS_W'(OS_LAST));
  assign dout_rdy   = r_dout_rdy;
  assign dout_byte  = r_dout_byte;
  assign frame_err  = r_frame_err;
  assign parity_err = r_par_err;
  assign busy       = (r_state != ST_IDLE);

  // 2-FF synchronizer; arm start detection only once the flushed line has been seen high
  always_ff @(posedge CLK)
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_flush   <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_rx_meta <= rxd;
      r_rx_sync <= r_rx_meta;
      r_flush   <= {r_flush[0], 1'b1};
      r_armed   <= r_armed | (r_flush[1] & r_rx_sync);
    end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  assign w_par_bad = r_par_bad;
  // even-parity check, sampled mid parity bit
  always_ff @(posedge CLK)
    if (!rst_n) r_par_bad <= 1'b0;
    else if (w_mid && r_state == ST_PARITY) r_par_bad <= (r_rx_sync != ^r_shift);
`else
  assign w_par_bad = 1'b0;
`endif

  // frame FSM: all state moves on oversample ticks, output pulses last one CLK
  always_ff @(posedge CLK)
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_os        <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_dout_rdy  <= 1'b0;
      r_dout_byte <= 8'h00;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      r_dout_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
      if (w_tick) begin
        r_os <= r_os + 1'b1;
        case (r_state)
          ST_IDLE: if (!r_rx_sync && r_armed) begin
            r_os    <= '0;
            r_state <= ST_START;
          end
          ST_START: if (r_os == OS_W'(OS_MID)) begin
            r_os    <= '0;
            r_idx   <= '0;
            r_state <= r_rx_sync ? ST_IDLE : ST_DATA;
          end
          ST_DATA: if (w_mid) begin
            r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
            r_idx   <= r_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (r_idx == IDX_W'(DATA_BITS - 1)) r_state <= ST_PARITY;
`else
            if (r_idx == IDX_W'(DATA_BITS - 1)) r_state <= ST_STOP;
`endif
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: if (w_mid) r_state <= ST_STOP;
`endif
          ST_STOP: if (w_mid) begin
            r_frame_err <= !r_rx_sync;
            r_par_err   <= r_rx_sync && w_par_bad;
            r_dout_rdy  <= r_rx_sync && !w_par_bad;
            if (r_rx_sync && !w_par_bad) r_dout_byte <= r_shift;
            r_state     <= r_rx_sync ? ST_IDLE : ST_BREAK;
          end
          ST_BREAK: if (r_rx_sync) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: randomized self-checking bench for uart_rx_os16 (OS_DIV=4, 64 CLK per bit), honours UART_RX_PARITY_EN
module tb_uart_rx_os16;
  localparam int BIT = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic dout_rdy, frame_err, parity_err, busy;
  logic [7:0] dout_byte;
  int total = 0, bad = 0;
  int n_rdy = 0, n_fe = 0, n_pe = 0, cyc = 0, rdy_cyc = 0, stop_cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_last = 8'h00;

  uart_rx_os16 #(.OS_DIV(4), .DIV_W(2)) dut (
    .CLK(CLK), .rst_n(rst_n), .rxd(rxd), .dout_rdy(dout_rdy), .dout_byte(dout_byte),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (dout_rdy) begin
      n_rdy++;
      rdy_cyc = cyc;
      got_q.push_back(dout_byte);
    end
    if (frame_err) n_fe++;
    if (parity_err) n_pe++;
  end

  function automatic logic ep(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    idle(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR) send_bit(par);
    stop_cyc = cyc;
    send_bit(stp);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(3);
    total += 5;
    if (dout_rdy !== 1'b0) begin bad++; $display("FAIL reset dout_rdy: got %b expected 0", dout_rdy); end
    if (dout_byte !== 8'h00) begin bad++; $display("FAIL reset dout_byte: got %h expected 00", dout_byte); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL reset frame_err: got %b expected 0", frame_err); end
    if (parity_err !== 1'b0) begin bad++; $display("FAIL reset parity_err: got %b expected 0", parity_err); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    idle(20);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle busy: got %b expected 0", busy); end
  endtask

  task automatic test_frame_a5;
    int s_f;
    got_q.delete();
    s_f = n_fe;
    send_frame(8'hA5, ep(8'hA5), 1'b1);
    exp_last = 8'hA5;
    idle(2 * BIT);
    total += 4;
    if (got_q.size() !== 1) begin bad++; $display("FAIL a5 count: got %0d expected 1", got_q.size()); end
    else if (got_q[0] !== 8'hA5) begin bad++; $display("FAIL a5 byte: got %h expected a5", got_q[0]); end
    if (dout_byte !== 8'hA5) begin bad++; $display("FAIL a5 held: got %h expected a5", dout_byte); end
    if (n_fe - s_f !== 0) begin bad++; $display("FAIL a5 frame_err: got %0d expected 0", n_fe - s_f); end
    if (rdy_cyc - stop_cyc < 30 || rdy_cyc - stop_cyc > 40) begin
      bad++; $display("FAIL a5 latency: got %0d expected 30..40", rdy_cyc - stop_cyc);
    end
  endtask

  task automatic test_false_start;
    int s_r, s_f, s_p;
    s_r = n_rdy; s_f = n_fe; s_p = n_pe;
    rxd = 1'b0;
    idle(20);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL glitch busy_high: got %b expected 1", busy); end
    rxd = 1'b1;
    idle(60);
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL glitch busy_low: got %b expected 0", busy); end
    if (n_rdy - s_r + n_fe - s_f + n_pe - s_p !== 0) begin
      bad++; $display("FAIL glitch pulses: got %0d expected 0", n_rdy - s_r + n_fe - s_f + n_pe - s_p);
    end
  endtask

  task automatic test_frame_err;
    int s_r, s_f;
    s_r = n_rdy; s_f = n_fe;
    send_frame(8'h3C, ep(8'h3C), 1'b0);
    total += 4;
    if (busy !== 1'b1) begin bad++; $display("FAIL break busy: got %b expected 1", busy); end
    if (n_fe - s_f !== 1) begin bad++; $display("FAIL break frame_err: got %0d expected 1", n_fe - s_f); end
    if (n_rdy - s_r !== 0) begin bad++; $display("FAIL break rdy: got %0d expected 0", n_rdy - s_r); end
    if (dout_byte !== exp_last) begin bad++; $display("FAIL break held: got %h expected %h", dout_byte, exp_last); end
    rxd = 1'b1;
    idle(20);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL break idle: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    got_q.delete();
    send_frame(8'h00, ep(8'h00), 1'b1);
    send_frame(8'hFF, ep(8'hFF), 1'b1);
    exp_last = 8'hFF;
    idle(2 * BIT);
    total += 1;
    if (got_q.size() !== 2) begin bad++; $display("FAIL b2b count: got %0d expected 2", got_q.size()); end
    else begin
      total += 2;
      if (got_q[0] !== 8'h00) begin bad++; $display("FAIL b2b first: got %h expected 00", got_q[0]); end
      if (got_q[1] !== 8'hFF) begin bad++; $display("FAIL b2b second: got %h expected ff", got_q[1]); end
    end
  endtask

  task automatic test_reset_mid;
    int s_r, s_f, s_p;
    logic [7:0] d;
    d = 8'h81;
    s_r = n_rdy; s_f = n_fe; s_p = n_pe;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rxd = d[4];
    idle(32);
    rst_n = 1'b0;
    idle(1);
    exp_last = 8'h00;
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid busy: got %b expected 0", busy); end
    if (dout_byte !== 8'h00) begin bad++; $display("FAIL rstmid byte: got %h expected 00", dout_byte); end
    rst_n = 1'b1;
    idle(31);
    send_bit(d[5]);
    send_bit(d[6]);
    rxd = 1'b1;
    idle(3 * BIT);
    total += 3;
    if (n_rdy - s_r + n_fe - s_f + n_pe - s_p !== 0) begin
      bad++; $display("FAIL rstmid pulses: got %0d expected 0", n_rdy - s_r + n_fe - s_f + n_pe - s_p);
    end
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid idle: got %b expected 0", busy); end
    if (dout_byte !== 8'h00) begin bad++; $display("FAIL rstmid held: got %h expected 00", dout_byte); end
    got_q.delete();
    send_frame(d, ep(d), 1'b1);
    exp_last = d;
    idle(2 * BIT);
    total++;
    if (got_q.size() !== 1 || dout_byte !== 8'h81) begin
      bad++; $display("FAIL rstmid next: got %0d bytes last %h expected 1 byte 81", got_q.size(), dout_byte);
    end
  endtask

  task automatic test_parity;
`ifdef UART_RX_PARITY_EN
    int s_r, s_p;
    s_r = n_rdy; s_p = n_pe;
    send_frame(8'h07, 1'b0, 1'b1);
    idle(2 * BIT);
    total += 3;
    if (n_pe - s_p !== 1) begin bad++; $display("FAIL par_bad pe: got %0d expected 1", n_pe - s_p); end
    if (n_rdy - s_r !== 0) begin bad++; $display("FAIL par_bad rdy: got %0d expected 0", n_rdy - s_r); end
    if (dout_byte !== exp_last) begin bad++; $display("FAIL par_bad held: got %h expected %h", dout_byte, exp_last); end
    s_r = n_rdy; s_p = n_pe;
    send_frame(8'h07, 1'b1, 1'b1);
    exp_last = 8'h07;
    idle(2 * BIT);
    total += 3;
    if (n_pe - s_p !== 0) begin bad++; $display("FAIL par_ok pe: got %0d expected 0", n_pe - s_p); end
    if (n_rdy - s_r !== 1) begin bad++; $display("FAIL par_ok rdy: got %0d expected 1", n_rdy - s_r); end
    if (dout_byte !== 8'h07) begin bad++; $display("FAIL par_ok byte: got %h expected 07", dout_byte); end
`else
    total++;
    if (n_pe !== 0) begin bad++; $display("FAIL no_parity pe: got %0d expected 0", n_pe); end
`endif
  endtask

  task automatic test_random;
    int s_r, s_f, s_p, e_r, e_f, e_p;
    logic [7:0] d;
    logic par, stp;
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      par = ep(d) ^ (PAR && $urandom_range(0, 3) == 0);
      e_r = 0; e_f = 0; e_p = 0;
      if (!stp) e_f = 1;
      else if (PAR && par != ep(d)) e_p = 1;
      else begin e_r = 1; exp_last = d; end
      s_r = n_rdy; s_f = n_fe; s_p = n_pe;
      send_frame(d, par, stp);
      rxd = 1'b1;
      idle(BIT + int'($urandom_range(0, 40)));
      total += 4;
      if (n_rdy - s_r !== e_r) begin bad++; $display("FAIL rand%0d rdy: got %0d expected %0d", k, n_rdy - s_r, e_r); end
      if (n_fe - s_f !== e_f) begin bad++; $display("FAIL rand%0d fe: got %0d expected %0d", k, n_fe - s_f, e_f); end
      if (n_pe - s_p !== e_p) begin bad++; $display("FAIL rand%0d pe: got %0d expected %0d", k, n_pe - s_p, e_p); end
      if (dout_byte !== exp_last) begin bad++; $display("FAIL rand%0d byte: got %h expected %h", k, dout_byte, exp_last); end
    end
  endtask

  initial begin
    test_reset;
    test_frame_a5;
    test_false_start;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    test_parity;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_os16.md
UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 Parameter OS_DIV, default 2604: CLK cycles per oversample tick (50 MHz / 2604 = 19200 Hz tick, 1200 baud).
REQ-002 Parameter DIV_W, default 12: width of the oversample tick counter; SHALL satisfy 2^DIV_W >= OS_DIV.
REQ-003 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rxd  input  1  asynchronous serial line, idle high.
REQ-006 dout_rdy  output  1  one-CLK pulse: new byte valid on dout_byte.
REQ-007 dout_byte  output  8  last correctly framed byte; held until the next good frame.
REQ-008 frame_err  output  1  one-CLK pulse: stop bit sampled low.
REQ-009 parity_err  output  1  one-CLK pulse: parity mismatch (constant 0 without the parity feature).
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 rxd SHALL pass through a 2-FF synchronizer; both flops reset to 1. All sampling uses the synchronized value.
REQ-012 Tick counter: 0..OS_DIV-1, wraps, free-running from reset; tick = 1 for one CLK when count == OS_DIV-1.
REQ-013 Per-bit counter os_cnt (4 bits) SHALL advance only on tick and wrap 15 -> 0.
REQ-014 States: IDLE, START, DATA, PARITY (parity build only), STOP, BREAK.
REQ-015 IDLE: on a tick with rxd == 0, clear os_cnt and go to START.
REQ-016 START: on the tick where os_cnt == 7, sample rxd. 1 -> false start, go to IDLE with no output. 0 -> clear os_cnt and bit index, go to DATA.
REQ-017 DATA: on the tick where os_cnt == 15 (mid-bit), shift rxd into the shift register, LSB first. After bit index 7 go to PARITY, or to STOP when parity is compiled out.
REQ-018 PARITY: sample at mid-bit; error if the sampled bit is not the even-parity value; go to STOP.
REQ-019 STOP: sample at mid-bit.
- rxd == 1 and no parity error: load dout_byte, pulse dout_rdy on the next CLK, go to IDLE.
- rxd == 1 with parity error: pulse parity_err, dout_byte unchanged, go to IDLE.
- rxd == 0: pulse frame_err, dout_byte unchanged, go to BREAK.
REQ-020 BREAK: stay until a tick sees rxd == 1, then go to IDLE. No start detection while in BREAK.
REQ-021 Latency: dout_rdy SHALL rise exactly 1 CLK after the tick on which the stop bit is sampled.
REQ-022 Error and ready pulses are mutually exclusive per frame; at most one pulse per frame.
REQ-023 A new start bit SHALL be accepted on the first tick after returning to IDLE; back-to-back frames SHALL lose no byte.

Reset
REQ-024 On rst_n == 0 at a CLK edge:
- state = IDLE; tick counter, os_cnt, bit index and shift register = 0.
- dout_rdy = 0, dout_byte = 8'h00, frame_err = 0, parity_err = 0, busy = 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no output pulse. The first frame after release requires a fresh falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN.
- Defined: frame is start, 8 data, even parity, stop; the PARITY state exists.
- Undefined: frame is start, 8 data, stop (8N1); the PARITY state is absent; parity_err is tied to 0.

Structure
REQ-027 Package uart_pkg SHALL hold:
- the rx state enum;
- constants OS_RATE = 16, OS_MID = 7, OS_LAST = 15, DATA_BITS = 8.
REQ-028 The tick generator SHALL be a separate sub-module uart_baud_tick (params OS_DIV, DIV_W; ports CLK, rst_n, tick). The transmitter reuses it.

Verification (bench uses OS_DIV = 4; parity build where stated)
REQ-029 8N1 frame 0xA5, 64 CLK per bit -> one dout_rdy pulse; dout_byte = 8'hA5; frame_err = 0.
REQ-030 rxd low for 20 CLK then high -> no dout_rdy; busy returns to 0 after the START sample.
REQ-031 Frame 0x3C with stop bit low, line then idle -> frame_err pulse; dout_byte keeps its prior value; state passes through BREAK to IDLE.
REQ-032 Back-to-back 0x00 then 0xFF, no idle gap -> two dout_rdy pulses with 8'h00 then 8'hFF.
REQ-033 rst_n low for 1 CLK during data bit 4 of 0x81 -> no pulse; dout_byte = 8'h00; the next 0x81 frame is received correctly.
REQ-034 Parity build, 0x07 sent with parity bit 0 -> parity_err pulse, no dout_rdy. Same byte with parity bit 1 -> dout_rdy, dout_byte = 8'h07.
